// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a build-time FWFT output mode.
module sync_fifo_flex #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  output logic              wr_rdy,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic              rd_rdy,
  output logic              empty,
  output logic              almost_empty,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wa;
  logic              ra;

  // Accept decisions look only at registered occupancy, never at the other port.
  assign wa = wr_en & ~full;
  assign ra = rd_en & ~empty;

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign wr_rdy       = ~full;
  assign rd_rdy       = ~empty;

  // NOTE: the storage array has no reset so it maps onto plain RAM; only
  // pointers and count define which entries are valid.
  always_ff @(posedge CLK) begin
    if (wa) mem[wr_ptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wa) wr_ptr <= wr_ptr + 1'b1;
      if (ra) rd_ptr <= rd_ptr + 1'b1;
      case ({wa, ra})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error event in the same cycle as clr_err keeps the flag set.
      overflow  <= (wr_en & full)  | (overflow  & ~clr_err);
      underflow <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign dout = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)  dout_q <= '0;
        else if (ra)   dout_q <= mem[rd_ptr];
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: a registered-read and an FWFT instance share
// one stimulus stream; a vector table covers the main flow, hand sequences the rest.
module tb_sync_fifo_flex;

  logic        CLK;
  logic        reset_n;
  logic [31:0] din;
  logic        wr_en, rd_en, clr_err;

  logic        wr_rdy_r, full_r, af_r, rd_rdy_r, empty_r, ae_r, ovf_r, unf_r;
  logic [31:0] dout_r;
  logic [3:0]  cnt_r;
  logic        wr_rdy_f, full_f, af_f, rd_rdy_f, empty_f, ae_f, ovf_f, unf_f;
  logic [31:0] dout_f;
  logic [3:0]  cnt_f;

  sync_fifo_flex #(.DATA_W(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)) u_reg (
    .CLK(CLK), .reset_n(reset_n), .din(din), .wr_en(wr_en), .wr_rdy(wr_rdy_r),
    .full(full_r), .almost_full(af_r), .rd_en(rd_en), .rd_rdy(rd_rdy_r),
    .empty(empty_r), .almost_empty(ae_r), .dout(dout_r), .count(cnt_r),
    .overflow(ovf_r), .underflow(unf_r), .clr_err(clr_err)
  );

  sync_fifo_flex #(.DATA_W(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b1)) u_fwft (
    .CLK(CLK), .reset_n(reset_n), .din(din), .wr_en(wr_en), .wr_rdy(wr_rdy_f),
    .full(full_f), .almost_full(af_f), .rd_en(rd_en), .rd_rdy(rd_rdy_f),
    .empty(empty_f), .almost_empty(ae_f), .dout(dout_f), .count(cnt_f),
    .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_err)
  );

  logic [43:0] act_reg, act_fwft;
  assign act_reg  = {cnt_r, empty_r, ae_r, full_r, af_r, wr_rdy_r, rd_rdy_r, ovf_r, unf_r, dout_r};
  assign act_fwft = {cnt_f, empty_f, ae_f, full_f, af_f, wr_rdy_f, rd_rdy_f, ovf_f, unf_f, dout_f};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr, rd, clr;
    logic [31:0] din;
    int          cnt;
    logic        ovf, unf;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Flags for DEPTH=8, AF_LEVEL=6, AE_LEVEL=2 derived from the expected count.
  function automatic logic [43:0] expect_out(input int cnt, input logic ovf, input logic unf,
                                             input logic [31:0] dout);
    logic [3:0] c;
    c = 4'(cnt);
    return {c, cnt == 0, cnt <= 2, cnt == 8, cnt >= 6, cnt != 8, cnt != 0, ovf, unf, dout};
  endfunction

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got cnt=%0d flags=%b dout=%h, expected cnt=%0d flags=%b dout=%h",
               name, act[43:40], act[39:32], act[31:0], exp[43:40], exp[39:32], exp[31:0]);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic clr, input logic [31:0] d,
                     input int cnt, input logic ovf, input logic unf, input logic [31:0] dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = d;
    v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.dout = dout;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic wr, input logic rd, input logic clr, input logic [31:0] d);
    wr_en = wr; rd_en = rd; clr_err = clr; din = d;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, '0);

    // Fill 1..8, then drain.
    for (int i = 1; i <= 8; i++) add(1, 0, 0, 32'(i), i, 0, 0, 32'h0);
    for (int i = 1; i <= 8; i++) add(0, 1, 0, '0, 8 - i, 0, 0, 32'(i));
    // Read+write on empty: only the write lands, underflow sets, then clears.
    add(1, 1, 0, 32'h55, 1, 0, 1, 32'h8);
    add(0, 0, 1, '0, 1, 0, 0, 32'h8);
    add(0, 1, 0, '0, 0, 0, 0, 32'h55);
    // Write 5, read 3, then 20 simultaneous cycles across pointer wraps.
    for (int i = 0; i < 5; i++) add(1, 0, 0, 32'h10 + 32'(i), i + 1, 0, 0, 32'h55);
    for (int i = 0; i < 3; i++) add(0, 1, 0, '0, 4 - i, 0, 0, 32'h10 + 32'(i));
    for (int k = 0; k < 20; k++)
      add(1, 1, 0, 32'h20 + 32'(k), 2, 0, 0,
          (k == 0) ? 32'h13 : (k == 1) ? 32'h14 : 32'h20 + 32'(k - 2));
    add(0, 1, 0, '0, 1, 0, 0, 32'h32);
    add(0, 1, 0, '0, 0, 0, 0, 32'h33);
    // Full boundary: read+write while full, clr_err, set-wins on clr.
    for (int i = 0; i < 8; i++) add(1, 0, 0, 32'h40 + 32'(i), i + 1, 0, 0, 32'h33);
    add(1, 1, 0, 32'hDEAD, 7, 1, 0, 32'h40);
    add(0, 0, 1, '0, 7, 0, 0, 32'h40);
    add(1, 0, 0, 32'h48, 8, 0, 0, 32'h40);
    add(1, 0, 1, 32'hBEEF, 8, 1, 0, 32'h40);
    for (int i = 0; i < 8; i++) add(0, 1, 0, '0, 7 - i, 1, 0, 32'h41 + 32'(i));
    add(0, 0, 1, '0, 0, 0, 0, 32'h48);
    add(0, 1, 1, '0, 0, 0, 1, 32'h48);
    add(0, 0, 1, '0, 0, 0, 0, 32'h48);

    repeat (2) @(posedge CLK);
    #3 reset_n = 1'b1;
    #1;
    check("reset_reg", act_reg, expect_out(0, 0, 0, '0));
    check("reset_fwft", act_fwft, expect_out(0, 0, 0, '0));

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      step();
      check($sformatf("vec%0d", i), act_reg,
            expect_out(vecs[i].cnt, vecs[i].ovf, vecs[i].unf, vecs[i].dout));
    end

    // FWFT: word appears without rd_en, pop returns dout to 0.
    drive(1, 0, 0, 32'hA5A5A5A5); step(); drive(0, 0, 0, '0);
    check("fwft_show", act_fwft, expect_out(1, 0, 0, 32'hA5A5A5A5));
    check("reg_hold", act_reg, expect_out(1, 0, 0, 32'h48));
    drive(0, 1, 0, '0); step(); drive(0, 0, 0, '0);
    check("fwft_pop", act_fwft, expect_out(0, 0, 0, '0));
    check("reg_pop", act_reg, expect_out(0, 0, 0, 32'hA5A5A5A5));
    drive(1, 0, 0, 32'h1); step();
    drive(1, 0, 0, 32'h2); step(); drive(0, 0, 0, '0);
    check("fwft_head", act_fwft, expect_out(2, 0, 0, 32'h1));
    drive(0, 1, 0, '0); step();
    check("fwft_next", act_fwft, expect_out(1, 0, 0, 32'h2));
    step(); drive(0, 0, 0, '0);
    check("fwft_drain", act_fwft, expect_out(0, 0, 0, '0));

    // Mid-operation asynchronous reset with count=4.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 32'h61 + 32'(i)); step();
    end
    drive(0, 0, 0, '0);
    check("pre_reset", act_reg, expect_out(4, 0, 0, 32'h2));
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_reg", act_reg, expect_out(0, 0, 0, '0));
    check("async_rst_fwft", act_fwft, expect_out(0, 0, 0, '0));
    #2 reset_n = 1'b1;
    drive(1, 0, 0, 32'h77); step();
    check("post_rst_fwft", act_fwft, expect_out(1, 0, 0, 32'h77));
    drive(0, 1, 0, '0); step(); drive(0, 0, 0, '0);
    check("post_rst_reg", act_reg, expect_out(0, 0, 0, 32'h77));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
